c3aibadapt_cmn_occ_burst_ctrl: RTL and testbench

- Multi-channel on-chip clock controller (OCC) enable generator for ATPG capture.
- On a synchronized rising edge of occ_enable, it issues a per-channel programmable burst of clock-enable cycles on one shared clock domain.
- Each channel has its own burst length and mask bit. Completion is reported with done/busy.
- Sits beside the adapter clock gates: one occ_clken bit drives one functional clock gate.

---
 rtl/c3aibadapt_cmn_occ_pkg.sv | 33 +++
 rtl/c3aibadapt_cmn_occ_bitsync_n.sv | 21 ++
 rtl/c3aibadapt_cmn_occ_burst_ctrl.sv | 109 ++++++++++
 tb/tb_c3aibadapt_cmn_occ_burst_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3aibadapt_cmn_occ_pkg.sv
// OCC burst controller shared definitions.
// State codes and the masked max-burst reduction.
package c3aibadapt_cmn_occ_pkg;

  localparam logic [1:0] OCC_IDLE  = 2'b00;
  localparam logic [1:0] OCC_BURST = 2'b01;
  localparam logic [1:0] OCC_DONE  = 2'b10;

  localparam int OCC_MAX_CH = 8;

  // Fields are w bits wide, packed from bit 0; up to 8 channels of 8 bits.
  function automatic logic [7:0] occ_max_burst(
    input logic [63:0] burst,
    input logic [7:0]  mask,
    input int          nch,
    input int          w
  );
    logic [7:0]  m;
    logic [7:0]  f;
    logic [7:0]  lim;
    logic [63:0] sh;
    m   = '0;
    lim = 8'hff >> (8 - w);
    for (int i = 0; i < OCC_MAX_CH; i++) begin
      sh = burst >> (i * w);
      f  = sh[7:0] & lim;
      if (i < nch && mask[i] && f > m)
        m = f;
    end
    return m;
  endfunction

endpackage

// File: rtl/c3aibadapt_cmn_occ_bitsync_n.sv
// N-stage single-bit synchronizer, async active-low reset.
// Output is the input after DEPTH capture edges.
module c3aibadapt_cmn_occ_bitsync_n #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/c3aibadapt_cmn_occ_burst_ctrl.sv
// Multi-channel OCC clock-enable burst generator for ATPG capture.
// One synchronized occ_enable rise yields per-channel enable bursts.
module c3aibadapt_cmn_occ_burst_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 3,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_enable,
  input  logic                    atpg_mode,
  input  logic                    occ_enable,
  input  logic [NUM_CH*CNT_W-1:0] burst_cnt,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic [NUM_CH-1:0]       occ_clken,
  output logic                    busy,
  output logic                    done
);

  import c3aibadapt_cmn_occ_pkg::*;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic                    s;
  logic                    s_d_q;
  logic                    rise_q;
  logic                    abort;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*CNT_W-1:0] bc_q, bc_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [NUM_CH-1:0]       clken_q, clken_d;
  logic [CNT_W-1:0]        mb_in;
  logic [CNT_W-1:0]        mb_lat;

  c3aibadapt_cmn_occ_bitsync_n #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (occ_enable),
    .q_o  (s)
  );

  assign mb_in  = CNT_W'(occ_max_burst(64'(burst_cnt), 8'(ch_mask),
                                       NUM_CH, CNT_W));
  assign mb_lat = CNT_W'(occ_max_burst(64'(bc_q), 8'(mask_q),
                                       NUM_CH, CNT_W));
  assign abort  = scan_enable | ~atpg_mode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q;
    mask_d  = mask_q;
    clken_d = '0;
    if (abort) begin
      state_d = OCC_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OCC_IDLE: begin
          cnt_d = '0;
          if (rise_q) begin
            bc_d    = burst_cnt;
            mask_d  = ch_mask;
            state_d = (mb_in != '0) ? OCC_BURST : OCC_DONE;
          end
        end
        OCC_BURST: begin
          for (int i = 0; i < NUM_CH; i++)
            clken_d[i] = mask_q[i] &
                         (cnt_q < bc_q[i*CNT_W +: CNT_W]);
          if (cnt_q == mb_lat - ONE) state_d = OCC_DONE;
          else                       cnt_d   = cnt_q + ONE;
        end
        OCC_DONE: begin
          if (!s) state_d = OCC_IDLE;
        end
        default: state_d = OCC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      state_q <= OCC_IDLE;
      cnt_q   <= '0;
      bc_q    <= '0;
      mask_q  <= '0;
      clken_q <= '0;
    end else begin
      s_d_q   <= s;
      rise_q  <= s & ~s_d_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      mask_q  <= mask_d;
      clken_q <= clken_d;
    end
  end

  assign occ_clken = atpg_mode ? clken_q : {NUM_CH{1'b1}};
  assign busy      = (state_q == OCC_BURST);
  assign done      = (state_q == OCC_DONE);

endmodule

// File: tb/tb_c3aibadapt_cmn_occ_burst_ctrl.sv
// Randomized self-checking bench for the OCC burst controller.
// Expected outputs come from an edge-indexed timing-window model.
module tb_c3aibadapt_cmn_occ_burst_ctrl;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 3;
  localparam int D      = 3;
  localparam int NW     = NUM_CH * CNT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scan_enable = 1'b0;
  logic              atpg_mode = 1'b1;
  logic              occ_enable = 1'b0;
  logic [NW-1:0]     burst_cnt = '0;
  logic [NUM_CH-1:0] ch_mask = '1;
  logic [NUM_CH-1:0] occ_clken;
  logic              busy;
  logic              done;

  c3aibadapt_cmn_occ_burst_ctrl #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .SYNC_DEPTH(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_enable(scan_enable),
    .atpg_mode  (atpg_mode),
    .occ_enable (occ_enable),
    .burst_cnt  (burst_cnt),
    .ch_mask    (ch_mask),
    .occ_clken  (occ_clken),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // model: edge count, enable history, accepted burst window
  int n = 0;
  int floor_n = 1;
  bit hist [0:8191];
  int mode = 0;
  int e = 0;
  int mx = 0;
  int L [NUM_CH];
  bit lm [NUM_CH];
  bit live = 0;

  int pc [NUM_CH];
  int busy_cyc;
  int done_cyc;
  int first_n;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h edge %0d",
               tag, got, exp, n);
    end
  endtask

  function automatic bit en_at(input int k);
    if (k < floor_n || k < 0) return 1'b0;
    return hist[k];
  endfunction

  function automatic logic [NUM_CH-1:0] exp_clken();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = live && n >= e + 1 && n <= e + L[i] && lm[i];
    return atpg_mode ? v : '1;
  endfunction

  task automatic model_step();
    bit r;
    bit sp;
    logic [NW-1:0] sh;
    r  = en_at(n - D - 1) & ~en_at(n - D - 2);
    sp = en_at(n - D);
    if (scan_enable || !atpg_mode) begin
      mode = 0;
      live = 0;
    end else if (mode == 0) begin
      if (r) begin
        mx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          sh    = burst_cnt >> (i * CNT_W);
          L[i]  = int'(sh[CNT_W-1:0]);
          lm[i] = ch_mask[i];
          if (lm[i] && L[i] > mx) mx = L[i];
        end
        e    = n;
        live = (mx > 0);
        mode = (mx > 0) ? 1 : 2;
      end
    end else if (mode == 1) begin
      if (n == e + mx) mode = 2;
    end else begin
      if (!sp) mode = 0;
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      n++;
      hist[n] = occ_enable;
      if (rst_n) model_step();
      @(negedge clk);
      chk("clken", 32'(occ_clken), 32'(exp_clken()));
      chk("busy", 32'(busy), 32'(mode == 1));
      chk("done", 32'(done), 32'(mode == 2));
      if (atpg_mode)
        for (int i = 0; i < NUM_CH; i++) pc[i] += int'(occ_clken[i]);
      busy_cyc += int'(busy);
      done_cyc += int'(done);
      if (atpg_mode && occ_clken[0] && first_n < 0) first_n = n;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < NUM_CH; i++) pc[i] = 0;
    busy_cyc = 0;
    done_cyc = 0;
    first_n  = -1;
  endtask

  task automatic run_burst(input logic [NW-1:0] bc,
                           input logic [NUM_CH-1:0] m,
                           input int hold,
                           input int e0,
                           input int e1,
                           input string tag);
    int st;
    burst_cnt  = bc;
    ch_mask    = m;
    clr();
    st         = n;
    occ_enable = 1'b1;
    cyc(hold);
    chk({tag, "_p0"}, 32'(pc[0]), 32'(e0));
    chk({tag, "_p1"}, 32'(pc[1]), 32'(e1));
    if (e0 > 0) chk({tag, "_lat"}, 32'(first_n - st), 32'(D + 3));
    occ_enable = 1'b0;
    cyc(6);
  endtask

  initial begin
    clr();
    #1;
    chk("rst_clken", 32'(occ_clken), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    atpg_mode = 1'b0;
    #1;
    chk("rst_bypass", 32'(occ_clken), 32'(2'b11));
    atpg_mode = 1'b1;
    cyc(2);
    rst_n   = 1'b1;
    floor_n = n + 1;
    cyc(3);

    run_burst({3'd1, 3'd3}, 2'b11, 16, 3, 1, "basic");
    chk("basic_busy", 32'(busy_cyc), 32'(3));
    run_burst({3'd1, 3'd3}, 2'b01, 16, 3, 0, "mask01");
    run_burst({3'd0, 3'd0}, 2'b11, 16, 0, 0, "zero");
    chk("zero_done", 32'(done_cyc > 0), 32'(1));
    run_burst({3'd7, 3'd7}, 2'b11, 40, 7, 7, "max");
    run_burst({3'd7, 3'd7}, 2'b11, 16, 7, 7, "rearm");

    // atpg_mode drop mid-burst
    burst_cnt  = {3'd7, 3'd7};
    occ_enable = 1'b1;
    cyc(7);
    atpg_mode = 1'b0;
    #1;
    chk("bypass_now", 32'(occ_clken), 32'(2'b11));
    cyc(2);
    atpg_mode  = 1'b1;
    occ_enable = 1'b0;
    cyc(8);

    // scan abort after the first enable cycle
    burst_cnt  = {3'd1, 3'd3};
    clr();
    occ_enable = 1'b1;
    cyc(6);
    scan_enable = 1'b1;
    cyc(1);
    scan_enable = 1'b0;
    cyc(2);
    chk("scan_p0", 32'(pc[0]), 32'(1));
    chk("scan_p1", 32'(pc[1]), 32'(1));
    occ_enable = 1'b0;
    cyc(6);
    run_burst({3'd1, 3'd3}, 2'b11, 16, 3, 1, "post_scan");

    // inputs changed after capture are ignored
    burst_cnt  = {3'd2, 3'd5};
    clr();
    occ_enable = 1'b1;
    cyc(7);
    burst_cnt = '0;
    ch_mask   = 2'b00;
    cyc(10);
    chk("latch_p0", 32'(pc[0]), 32'(5));
    chk("latch_p1", 32'(pc[1]), 32'(2));
    occ_enable = 1'b0;
    ch_mask    = 2'b11;
    cyc(6);

    // async reset mid-burst
    burst_cnt  = {3'd6, 3'd6};
    occ_enable = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clken", 32'(occ_clken), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    mode = 0;
    live = 0;
    cyc(2);
    occ_enable = 1'b0;
    rst_n      = 1'b1;
    floor_n    = n + 1;
    cyc(6);

    // bypass with toggling trigger
    atpg_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) occ_enable = ~occ_enable;
      cyc(1);
    end
    atpg_mode  = 1'b1;
    occ_enable = 1'b0;
    cyc(8);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) occ_enable = ~occ_enable;
      scan_enable = ($urandom_range(0, 39) == 0);
      atpg_mode   = ($urandom_range(0, 49) != 0);
      burst_cnt   = NW'($urandom);
      ch_mask     = NUM_CH'($urandom);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
